// File: rtl/uop_queue_pkg.sv
// UopQueueConsts: shared micro-op types (MicroCode, UopEntry, IntReg) and queue depth limits
package UopQueueConsts;
  localparam int REG_W = 5;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
  localparam int DEPTH_DEF = 4;
  typedef logic [31:0] IntReg;
  typedef struct packed {
    logic alu_en;
    logic mul_en;
    logic lsu_en;
    logic br_en;
    logic rd_en;
    logic [REG_W-1:0] rd_addr;
    logic [REG_W-1:0] rs1_addr;
    logic [REG_W-1:0] rs2_addr;
    logic [3:0] alu_op;
  } MicroCode;
  typedef struct packed {
    MicroCode uop;
    IntReg pc;
  } UopEntry;
endpackage

// File: rtl/uop_queue_if.sv
// uop_queue_if: enq (valid/ready/uop/pc) and deq (valid/ready/uop/pc) handshakes; master = producer/consumer, slave = queue
interface uop_queue_if;
  import UopQueueConsts::*;
  logic enq_valid;
  logic enq_ready;
  MicroCode enq_uop;
  IntReg enq_pc;
  logic deq_valid;
  logic deq_ready;
  MicroCode deq_uop;
  IntReg deq_pc;
  modport master (output enq_valid, enq_uop, enq_pc, deq_ready, input enq_ready, deq_valid, deq_uop, deq_pc);
  modport slave (input enq_valid, enq_uop, enq_pc, deq_ready, output enq_ready, deq_valid, deq_uop, deq_pc);
endinterface

// File: rtl/uop_queue_rd_match.sv
// uop_queue_rd_match: busy=1 when chk_addr!=0 and any candidate entry's rd_addr equals chk_addr (cand = live && rd_en)
module uop_queue_rd_match
  import UopQueueConsts::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0] cand,
  input  logic [REG_W-1:0] rd_addr [DEPTH],
  input  logic [REG_W-1:0] chk_addr,
  output logic             busy
);
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = cand[i] && (rd_addr[i] == chk_addr);
  end
  assign busy = (chk_addr != '0) && (|hit);
endmodule

// File: rtl/uop_queue.sv
// uop_queue: circular micro-op queue; ports clk, rst, flush, q (slave handshakes), count, chk_addr -> chk_busy pending-write check
module uop_queue
  import UopQueueConsts::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  uop_queue_if.slave       q,
  output logic [CNT_W-1:0] count,
  input  logic [REG_W-1:0] chk_addr,
  output logic             chk_busy
);
  localparam int PW = $clog2(DEPTH);
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uop_queue: DEPTH must be a power of two in 2..16");
  end
  UopEntry mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, off;
  logic [DEPTH-1:0] cand;
  logic [REG_W-1:0] rd_addr [DEPTH];
  logic enq, deq;
  assign q.enq_ready = count != CNT_W'(DEPTH);
  assign q.deq_valid = count != '0;
  assign enq = q.enq_valid && q.enq_ready && !flush;
  assign deq = q.deq_valid && q.deq_ready && !flush;
  assign q.deq_uop = q.deq_valid ? mem[rd_ptr].uop : '0;
  assign q.deq_pc = q.deq_valid ? mem[rd_ptr].pc : '0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(deq);
      wr_ptr <= wr_ptr + PW'(enq);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr] <= {q.enq_uop, q.enq_pc};
  // an entry is live when its distance from rd_ptr (mod DEPTH) is below count
  always_comb begin
    cand = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      cand[i] = (CNT_W'(off) < count) && mem[i].uop.rd_en;
      rd_addr[i] = mem[i].uop.rd_addr;
    end
  end
  uop_queue_rd_match #(.DEPTH(DEPTH)) u_rd_match (
    .cand(cand),
    .rd_addr(rd_addr),
    .chk_addr(chk_addr),
    .busy(chk_busy)
  );
endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: directed and random stimulus against a queue-based reference model
module tb_uop_queue;
  import UopQueueConsts::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic [CNT_W-1:0] count;
  logic [REG_W-1:0] chk_addr = '0;
  logic chk_busy;
  int n_chk = 0;
  int n_fail = 0;
  UopEntry mq[$];
  uop_queue_if ifc ();
  uop_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .q(ifc),
    .count(count),
    .chk_addr(chk_addr),
    .chk_busy(chk_busy)
  );
  always #5 clk = ~clk;

  function automatic MicroCode mk(input logic en, input logic [REG_W-1:0] rd);
    MicroCode m;
    m = '0;
    m.alu_en = 1'b1;
    m.rd_en = en;
    m.rd_addr = rd;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic busy;
    busy = 1'b0;
    foreach (mq[k]) if (mq[k].uop.rd_en && mq[k].uop.rd_addr == chk_addr) busy = 1'b1;
    busy = busy && (chk_addr != 0);
    chk("count", 64'(count), 64'(mq.size()));
    chk("enq_ready", 64'(ifc.enq_ready), 64'(mq.size() != DEPTH));
    chk("deq_valid", 64'(ifc.deq_valid), 64'(mq.size() != 0));
    chk("deq_pc", 64'(ifc.deq_pc), mq.size() != 0 ? 64'(mq[0].pc) : 64'd0);
    chk("deq_uop", 64'(ifc.deq_uop), mq.size() != 0 ? 64'(mq[0].uop) : 64'd0);
    chk("chk_busy", 64'(chk_busy), 64'(busy));
  endtask

  task automatic cyc(input logic ev, input logic dr, input logic fl, input logic r,
                     input IntReg pc, input MicroCode u, input logic [REG_W-1:0] ca);
    logic do_enq, do_deq;
    @(negedge clk);
    ifc.enq_valid = ev;
    ifc.deq_ready = dr;
    ifc.enq_pc = pc;
    ifc.enq_uop = u;
    flush = fl;
    rst = r;
    chk_addr = ca;
    #1;
    if (!rst) check_model();
    @(posedge clk);
    if (r || fl) mq.delete();
    else begin
      do_enq = ev && mq.size() != DEPTH;
      do_deq = dr && mq.size() != 0;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(UopEntry'({u, pc}));
    end
    #1;
  endtask

  initial begin
    IntReg exp_order[5];
    MicroCode ru;
    logic [31:0] rv;
    exp_order = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    ifc.enq_valid = 0;
    ifc.deq_ready = 0;
    ifc.enq_pc = '0;
    ifc.enq_uop = '0;
    cyc(1, 1, 0, 1, 32'h0, mk(1, 5), 5);
    cyc(0, 0, 0, 1, 32'h0, mk(1, 5), 5);
    chk("rst_count", 64'(count), 0);
    chk("rst_enq_ready", 64'(ifc.enq_ready), 1);
    chk("rst_deq_valid", 64'(ifc.deq_valid), 0);
    chk("rst_deq_uop", 64'(ifc.deq_uop), 0);
    chk("rst_deq_pc", 64'(ifc.deq_pc), 0);
    chk("rst_chk_busy", 64'(chk_busy), 0);
    // two enqueues, head visible one cycle after the first
    cyc(1, 0, 0, 0, 32'h100, mk(1, 1), 0);
    chk("lat_deq_pc", 64'(ifc.deq_pc), 64'h100);
    cyc(1, 0, 0, 0, 32'h104, mk(1, 2), 0);
    chk("two_count", 64'(count), 2);
    chk("two_deq_pc", 64'(ifc.deq_pc), 64'h100);
    // fill, hold a fifth entry, release it with one dequeue, then drain across the wrap
    cyc(1, 0, 0, 0, 32'h108, mk(1, 3), 0);
    cyc(1, 0, 0, 0, 32'h10C, mk(1, 4), 0);
    chk("full_count", 64'(count), 4);
    chk("full_enq_ready", 64'(ifc.enq_ready), 0);
    cyc(1, 0, 0, 0, 32'h110, mk(1, 6), 0);
    chk("held_count", 64'(count), 4);
    cyc(1, 1, 0, 0, 32'h110, mk(1, 6), 0);
    chk("full_deq_count", 64'(count), 3);
    cyc(1, 0, 0, 0, 32'h110, mk(1, 6), 0);
    chk("refill_count", 64'(count), 4);
    for (int k = 0; k < 4; k++) begin
      chk("order", 64'(ifc.deq_pc), 64'(exp_order[k + 1]));
      cyc(0, 1, 0, 0, 32'h0, mk(0, 0), 0);
    end
    chk("drained_count", 64'(count), 0);
    // steady-state simultaneous enqueue/dequeue at count=2
    cyc(1, 0, 0, 0, 32'h200, mk(1, 7), 0);
    cyc(1, 0, 0, 0, 32'h204, mk(1, 8), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0, 32'h208 + 4 * i, mk(1, 9), 0);
      chk("steady_count", 64'(count), 2);
      chk("steady_head", 64'(ifc.deq_pc), 64'(32'h204 + 4 * i));
    end
    cyc(0, 0, 1, 0, 32'h0, mk(0, 0), 0);
    // pending-write check against x5 and x0
    cyc(1, 0, 0, 0, 32'h300, mk(1, 5), 5);
    cyc(1, 0, 0, 0, 32'h304, mk(1, 0), 5);
    chk("busy_x5", 64'(chk_busy), 1);
    chk_addr = 0;
    #1;
    chk("busy_x0", 64'(chk_busy), 0);
    cyc(0, 1, 0, 0, 32'h0, mk(0, 0), 5);
    chk("busy_after_deq", 64'(chk_busy), 0);
    cyc(0, 0, 1, 0, 32'h0, mk(0, 0), 0);
    // flush with concurrent enqueue and dequeue
    cyc(1, 0, 0, 0, 32'h400, mk(1, 1), 0);
    cyc(1, 0, 0, 0, 32'h404, mk(1, 2), 0);
    cyc(1, 0, 0, 0, 32'h408, mk(1, 3), 0);
    cyc(1, 1, 1, 0, 32'h4FF, mk(1, 4), 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_deq_valid", 64'(ifc.deq_valid), 0);
    chk("flush_deq_uop", 64'(ifc.deq_uop), 0);
    cyc(1, 0, 0, 0, 32'h500, mk(1, 5), 0);
    chk("post_flush_head", 64'(ifc.deq_pc), 64'h500);
    cyc(0, 1, 0, 0, 32'h0, mk(0, 0), 0);
    // reset mid-stream with a full queue
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 32'h600 + 4 * i, mk(1, 6), 0);
    cyc(1, 1, 1, 1, 32'h6FF, mk(1, 6), 0);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_enq_ready", 64'(ifc.enq_ready), 1);
    cyc(1, 0, 0, 0, 32'h700, mk(1, 7), 0);
    chk("midrst_head", 64'(ifc.deq_pc), 64'h700);
    cyc(0, 1, 0, 0, 32'h0, mk(0, 0), 0);
    chk("midrst_empty", 64'(count), 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rv = $urandom;
      ru = rv[$bits(MicroCode)-1:0];
      ru.rd_addr = REG_W'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
          $urandom_range(0, 63) == 0, $urandom, ru, REG_W'($urandom_range(0, 7)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, number of entries (power of two, 2..16).
REQ-002 The parameter list SHALL be: CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 The port list SHALL be: clk  in  1  single clock, all state updates on its rising edge.
REQ-004 The port list SHALL be: rst  in  1  reset, synchronous, active-high.
REQ-005 The port list SHALL be: flush  in  1  discard all entries, for branch or trap redirect.
REQ-006 The port list SHALL be: enq_valid  in  1  producer (decode) offers an entry.
REQ-007 The port list SHALL be: enq_ready  out  1  queue accepts an entry this cycle.
REQ-008 The port list SHALL be: enq_uop  in  MicroCode  decoded micro-op.
REQ-009 The port list SHALL be: enq_pc  in  32  PC of the micro-op.
REQ-010 The port list SHALL be: deq_valid  out  1  head entry available.
REQ-011 The port list SHALL be: deq_ready  in  1  consumer (execute) takes the head.
REQ-012 The port list SHALL be: deq_uop  out  MicroCode  head micro-op.
REQ-013 The port list SHALL be: deq_pc  out  32  head PC.
REQ-014 The port list SHALL be: count  out  CNT_W  current occupancy, 0..DEPTH.
REQ-015 The port list SHALL be: chk_addr  in  5  register index to test for a pending write.
REQ-016 The port list SHALL be: chk_busy  out  1  some queued entry will write chk_addr.

Function
REQ-017 The queue SHALL be a circular buffer with rd_ptr and wr_ptr (log2 DEPTH bits, natural wrap from DEPTH-1 to 0) and a count register.
REQ-018 enq_ready SHALL equal (count != DEPTH); it SHALL NOT depend on deq_ready, so a full queue accepts no entry even when a dequeue occurs in the same cycle.
REQ-019 Enqueue SHALL occur when enq_valid && enq_ready && !flush: write the entry at wr_ptr, then advance wr_ptr.
REQ-020 Dequeue SHALL occur when deq_valid && deq_ready && !flush: advance rd_ptr.
REQ-021 count SHALL update each cycle as count + enq - deq; a simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-022 deq_valid SHALL equal (count != 0); enqueue-to-dequeue latency SHALL be exactly 1 cycle, with no combinational path from enq_* to deq_*.
REQ-023 When deq_valid=0, deq_uop and deq_pc SHALL read as all-zero, so that every unit enable and rd_en are 0 (safe bubble).
REQ-024 A producer holding enq_valid=1 while enq_ready=0 SHALL keep its entry; an entry SHALL be neither lost nor duplicated.
REQ-025 On flush, the next-cycle state SHALL be count=0 and rd_ptr=wr_ptr=0; an enqueue or dequeue in the flush cycle SHALL be ignored.
REQ-026 chk_busy SHALL be combinational and SHALL be 1 iff chk_addr != 0 and some valid entry (from rd_ptr, count entries) has rd_en=1 and rd_addr=chk_addr.
REQ-027 chk_busy SHALL reflect registered state only; the entry being enqueued in the current cycle SHALL NOT be included.
REQ-028 Entry storage SHALL have no reset; validity SHALL derive solely from the pointers and count.

Reset
REQ-029 While rst=1 at a clock edge, count, rd_ptr and wr_ptr SHALL become 0.
REQ-030 After reset, the outputs SHALL be: enq_ready=1, deq_valid=0, deq_uop=0, deq_pc=0, count=0, chk_busy=0.
REQ-031 rst SHALL override flush and all handshakes, including when asserted mid-operation with a full queue.

Structure
REQ-032 The entry struct UopEntry {MicroCode uop; IntReg pc;} SHALL be defined in the shared MicroCode header beside MicroCode, not inside the module.
REQ-033 DEPTH limits and any queue constants SHALL live in a shared package, UopQueueConsts.
REQ-034 The per-entry rd_addr comparison and OR-reduction SHALL be a single sub-module, uop_queue_rd_match (combinational); all sequential logic SHALL stay in uop_queue.

Verification
REQ-035 Reset, then enqueue pc=0x100 and then 0x104 with deq_ready=0 -> count=2, deq_pc=0x100 one cycle after the first enqueue.
REQ-036 With DEPTH=4, enqueue 4 entries -> enq_ready=0 and count=4; a 5th held entry enters only after one dequeue, and dequeue order is 0x100, 0x104, 0x108, 0x10C, 0x110 (wrap exercised).
REQ-037 At count=2, apply a simultaneous enqueue and dequeue for 10 cycles -> count stays 2, FIFO order preserved, no gaps.
REQ-038 With entries writing x5 (rd_en=1) and x0 -> chk_busy=1 for chk_addr=5, 0 for chk_addr=0, and drops to 0 the cycle after the x5 entry dequeues.
REQ-039 At count=3, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_uop=0, and the flushed-cycle entry never appears.
REQ-040 Assert rst mid-stream with the queue full -> next cycle count=0, enq_ready=1, and a subsequent enqueue dequeues correctly.
